// File: rtl/step_pulse_gen.sv
// Step pulse generator: debounced manual step or timed auto-step, issued one pulse at a time
// while the CPU controller is idle. Also counts issued steps.
module step_pulse_gen #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int RUN_PERIOD      = 1000,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_raw,
   input  logic             run_en,
   input  logic             halt,
   input  logic             idle,
   output logic             step,
   output logic             pending,
   output logic             btn_level,
   output logic [CNT_W-1:0] step_count
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int TMR_W = $clog2(RUN_PERIOD);
   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(RUN_PERIOD - 1);

   typedef enum logic [1:0] {S_WAIT, S_PENDING, S_ISSUE, S_COOLDOWN} state_t;

   logic             btn_meta, btn_sync;
   logic             run_meta, run_sync, run_prev;
   logic             btn_prev;
   logic [DB_W-1:0]  db_cnt;
   logic [TMR_W-1:0] run_timer;
   logic             btn_rise;
   logic             req_src;
   state_t           state, state_nxt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
         run_meta <= 1'b0;
         run_sync <= 1'b0;
      end else begin
         btn_meta <= btn_raw;
         btn_sync <= btn_meta;
         run_meta <= run_en;
         run_sync <= run_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_level <= 1'b0;
         btn_prev  <= 1'b0;
         db_cnt    <= '0;
      end else begin
         btn_prev <= btn_level;
         if (btn_sync != btn_level) begin
            if (db_cnt == DB_LAST) begin
               btn_level <= btn_sync;
               db_cnt    <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   assign btn_rise = btn_level & ~btn_prev;
   assign req_src  = run_sync ? (run_timer == '0) : btn_rise;

   // Timer only advances while waiting, so the step period excludes the controller's busy time.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_timer <= TMR_RELOAD;
         run_prev  <= 1'b0;
      end else begin
         run_prev <= run_sync;
         if (run_sync != run_prev) begin
            run_timer <= TMR_RELOAD;
         end else if (run_sync && state == S_WAIT) begin
            run_timer <= (run_timer == '0) ? TMR_RELOAD : run_timer - 1'b1;
         end
      end
   end

   // NOTE: next-state is defaulted to the current state first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         S_WAIT:     if (!halt && req_src) state_nxt = S_PENDING;
         S_PENDING: begin
            if (halt)      state_nxt = S_WAIT;
            else if (idle) state_nxt = S_ISSUE;
         end
         S_ISSUE:    state_nxt = S_COOLDOWN;
         S_COOLDOWN: if (!idle) state_nxt = S_WAIT;
         default:    state_nxt = S_WAIT;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_WAIT;
         step       <= 1'b0;
         pending    <= 1'b0;
         step_count <= '0;
      end else begin
         state   <= state_nxt;
         step    <= (state_nxt == S_ISSUE);
         pending <= (state_nxt == S_PENDING);
         if (state_nxt == S_ISSUE) step_count <= step_count + 1'b1;
      end
   end

endmodule
